// File: rtl/rx_frame_sequencer.sv
// ============================================================================
// rx_frame_sequencer
// Oversampled UART receive sequencer: start/data/stop framing with
// ready, framing-error and overrun flags. Rev 1.0
// ============================================================================
`default_nettype none

module rx_frame_sequencer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 new_packet_detected,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int CNT_W = 8;
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    LOAD  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       r_clk_cnt;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_stop;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_data_ready;
  logic                   r_framing_error;
  logic                   r_overrun_error;

  logic w_wrap;
  logic w_sample;
  logic w_load_good;

  assign w_wrap      = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_sample    = (r_clk_cnt == CNT_W'(CLKS_PER_BIT / 2));
  assign w_load_good = (r_state == LOAD) && r_stop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (new_packet_detected) w_next_state = START;
      // A high line at the start midpoint is glitch noise, not a frame.
      START:   if (w_sample && serial_in) w_next_state = IDLE;
               else if (w_wrap)           w_next_state = DATA;
      DATA:    if (w_wrap && (r_bit_idx == IDX_W'(DATA_BITS))) w_next_state = STOP;
      STOP:    if (w_sample) w_next_state = LOAD;
      LOAD:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_stop    <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_clk_cnt <= '0;
        r_bit_idx <= '0;
      end else begin
        r_clk_cnt <= w_wrap ? '0 : r_clk_cnt + 1'b1;
        if (w_wrap) r_bit_idx <= r_bit_idx + 1'b1;
      end
      if ((r_state == DATA) && w_sample) r_shift <= {serial_in, r_shift[DATA_BITS-1:1]};
      if ((r_state == STOP) && w_sample) r_stop <= serial_in;
    end
  end

  // A good load takes priority over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data       <= '0;
      r_data_ready    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
    end else if (w_load_good) begin
      r_rx_data       <= r_shift;
      r_data_ready    <= 1'b1;
      r_framing_error <= 1'b0;
      r_overrun_error <= ~data_read & (r_overrun_error | r_data_ready);
    end else begin
      if (r_state == LOAD) r_framing_error <= 1'b1;
      if (data_read) begin
        r_data_ready    <= 1'b0;
        r_overrun_error <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign framing_error = r_framing_error;
  assign overrun_error = r_overrun_error;

endmodule

`default_nettype wire

// File: doc/rx_frame_sequencer.md
RX_FRAME_SEQUENCER -- requirements
Module: rx_frame_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10: clock cycles per serial bit period, with an allowed range of 4..255.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, with an allowed range of 5..8.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port new_packet_detected, input, 1 bit: one-cycle falling-edge indication from the start-bit detector.
REQ-006 SHALL have port serial_in, input, 1 bit: synchronized serial line, idle high.
REQ-007 SHALL have port data_read, input, 1 bit: consumer acknowledge of rx_data.
REQ-008 SHALL have port rx_data, output, DATA_BITS bits: last good received word, LSB-aligned.
REQ-009 SHALL have port data_ready, output, 1 bit: rx_data holds an unread word.
REQ-010 SHALL have port framing_error, output, 1 bit: the last frame had a stop bit of 0.
REQ-011 SHALL have port overrun_error, output, 1 bit: a word was overwritten before it was read.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, LOAD.
REQ-013 In IDLE with new_packet_detected=1 at a clock edge, SHALL enter START with clk_cnt=0 and bit_idx=0.
REQ-014 Outside IDLE, SHALL ignore new_packet_detected.
REQ-015 Outside IDLE, clk_cnt SHALL increment every cycle and wrap from CLKS_PER_BIT-1 to 0; bit_idx SHALL increment on each wrap.
REQ-016 The sample point SHALL be registered clk_cnt == CLKS_PER_BIT/2 (integer division); serial_in SHALL be sampled exactly once per bit period.
REQ-017 START sample = 1: SHALL treat it as a false start, return to IDLE, and leave all outputs unchanged.
REQ-018 START sample = 0: SHALL go to DATA at the next wrap.
REQ-019 DATA: SHALL shift serial_in into an internal shift register LSB first, one bit per sample; after DATA_BITS samples it SHALL go to STOP at the next wrap.
REQ-020 STOP sample: SHALL capture the stop bit and enter LOAD on the same edge, without waiting for the wrap.
REQ-021 LOAD SHALL last exactly one cycle, then return to IDLE.
REQ-022 LOAD with stop=1: SHALL copy the shift register to rx_data, set data_ready, and clear framing_error.
REQ-023 LOAD with stop=0: SHALL set framing_error and leave rx_data and data_ready unchanged.
REQ-024 LOAD with stop=1 while data_ready=1 and data_read=0: SHALL set overrun_error and overwrite rx_data.
REQ-025 data_read=1 outside a LOAD-with-stop=1 cycle: SHALL clear data_ready and overrun_error on the next edge.
REQ-026 data_read=1 in the same cycle as a LOAD with stop=1: the load SHALL win, with data_ready staying 1 and overrun_error not set.
REQ-027 Latency with CLKS_PER_BIT=10 and DATA_BITS=8: data_ready SHALL rise on the 97th rising edge after the edge that registered new_packet_detected.
REQ-028 SHALL return to IDLE after LOAD in time for a back-to-back frame whose start edge follows the stop-bit midpoint.
REQ-029 All outputs SHALL be driven directly from registers.

Reset
REQ-030 On n_rst=0, SHALL immediately force state=IDLE, clk_cnt=0, bit_idx=0, shift register=0, rx_data=0, data_ready=0, framing_error=0, overrun_error=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no load; after release, the block SHALL wait in IDLE for a new new_packet_detected.

Verification
REQ-032 Frame 0xA5 with stop=1 at 10 clk/bit -> rx_data=0xA5 and data_ready=1 at edge 97, framing_error=0.
REQ-033 Frame 0x3C with stop=0 -> framing_error=1, and rx_data and data_ready keep their prior values.
REQ-034 Frames 0x11 then 0x22 back-to-back, no data_read -> rx_data=0x22, data_ready=1, overrun_error=1; then data_read pulse -> data_ready=0, overrun_error=0.
REQ-035 new_packet_detected pulse with serial_in back high by the start sample -> FSM returns to IDLE, all outputs unchanged.
REQ-036 n_rst pulse at bit 4 of a frame, then a clean frame 0xFF -> no output change from the aborted frame, then rx_data=0xFF with data_ready=1.
REQ-037 data_read asserted in the LOAD cycle of frame 0x5A while data_ready=1 -> data_ready=1, rx_data=0x5A, overrun_error=0.
